// File: rtl/prog_loader_ctrl.sv
// rtl/prog_loader_ctrl.sv - program loader: instruction load, data preload, run window, data dump
module prog_loader_ctrl #(
    parameter int CNT_W = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] n_inst,
    input  logic [LEN_W-1:0] n_data,
    input  logic [LEN_W-1:0] n_dump,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] cyc, cyc_nxt;
    logic [LEN_W-1:0] ni_q, nd_q, nn_q;
    logic [CNT_W-1:0] rc_q;
    logic             latch, cap;

    // First non-empty phase at or after the given point; from: 0 start, 1 after LOAD_I, 2 after LOAD_D, 3 after RUN.
    function automatic state_t skip_chain(input logic [1:0] from, input logic [LEN_W-1:0] ni,
                                          input logic [LEN_W-1:0] nd, input logic [LEN_W-1:0] nn,
                                          input logic [CNT_W-1:0] rc);
        if (from == 2'd0 && ni != '0) return S_LOAD_I;
        if (from <= 2'd1 && nd != '0) return S_LOAD_D;
        if (from <= 2'd2 && rc != '0) return S_RUN;
        if (nn != '0) return S_DUMP_RD;
        return S_DONE;
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            cyc      <= '0;
            ni_q     <= '0;
            nd_q     <= '0;
            nn_q     <= '0;
            rc_q     <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cyc   <= cyc_nxt;
            if (latch) begin
                ni_q <= n_inst;
                nd_q <= n_data;
                nn_q <= n_dump;
                rc_q <= run_cycles;
            end
            if (cap) out_data <= rdata_ext_2;
        end
    end

    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign ren_ext = 1'b0;

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cyc_nxt     = cyc;
        latch       = 1'b0;
        cap         = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        cpu_enable  = 1'b0;
        wen_ext     = 1'b0;
        addr_ext    = '0;
        wdata_ext   = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = '0;
        wdata_ext_2 = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    latch     = 1'b1;
                    idx_nxt   = '0;
                    cyc_nxt   = '0;
                    state_nxt = skip_chain(2'd0, n_inst, n_data, n_dump, run_cycles);
                end
            end
            S_LOAD_I: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wen_ext   = 1'b1;
                    addr_ext  = {{(62-LEN_W){1'b0}}, idx, 2'b00};
                    wdata_ext = in_data[31:0];
                    if (idx == ni_q - LEN_ONE) begin
                        idx_nxt   = '0;
                        state_nxt = skip_chain(2'd1, ni_q, nd_q, nn_q, rc_q);
                    end else begin
                        idx_nxt = idx + LEN_ONE;
                    end
                end
            end
            S_LOAD_D: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wen_ext_2   = 1'b1;
                    addr_ext_2  = {{(61-LEN_W){1'b0}}, idx, 3'b000};
                    wdata_ext_2 = in_data;
                    if (idx == nd_q - LEN_ONE) begin
                        idx_nxt   = '0;
                        state_nxt = skip_chain(2'd2, ni_q, nd_q, nn_q, rc_q);
                    end else begin
                        idx_nxt = idx + LEN_ONE;
                    end
                end
            end
            S_RUN: begin
                cpu_enable = 1'b1;
                if (cyc == rc_q - CNT_ONE) begin
                    cyc_nxt   = '0;
                    state_nxt = skip_chain(2'd3, ni_q, nd_q, nn_q, rc_q);
                end else begin
                    cyc_nxt = cyc + CNT_ONE;
                end
            end
            S_DUMP_RD: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = {{(61-LEN_W){1'b0}}, idx, 3'b000};
                state_nxt  = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                cap       = 1'b1;
                state_nxt = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx == nn_q - LEN_ONE) begin
                        idx_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx + LEN_ONE;
                        state_nxt = S_DUMP_RD;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// tb/tb_prog_loader_ctrl.sv - randomized self-checking bench for prog_loader_ctrl
module tb_prog_loader_ctrl;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start = 1'b0;
    logic [15:0] n_inst = '0, n_data = '0, n_dump = '0;
    logic [31:0] run_cycles = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy, done, cpu_enable;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext;
    logic [63:0] rdata_ext_2 = '0;

    always #5 clk = ~clk;

    prog_loader_ctrl #(.CNT_W(32), .LEN_W(16)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .n_inst(n_inst), .n_data(n_data), .n_dump(n_dump), .run_cycles(run_cycles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    // Memories the controller drives, and the reference contents they should end up holding.
    logic [31:0] imem [0:255];
    logic [63:0] dmem [0:255];
    logic [31:0] exp_imem [0:255];
    logic [63:0] exp_dmem [0:255];

    int n_checks = 0;
    int n_fail = 0;
    int en_cnt, en_runs, wr_i, wr_d;
    bit ren_bad, dflt_bad, hold_bad, prev_stall, prev_en;
    logic [63:0] prev_out;
    logic [63:0] got_dump [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[10:3]];

    always @(negedge clk) begin
        if (cpu_enable) en_cnt++;
        if (cpu_enable && !prev_en) en_runs++;
        prev_en = cpu_enable;
        if (wen_ext) begin
            imem[addr_ext[9:2]] = wdata_ext;
            wr_i++;
        end
        if (wen_ext_2) begin
            dmem[addr_ext_2[10:3]] = wdata_ext_2;
            wr_d++;
        end
        if (ren_ext) ren_bad = 1'b1;
        if (!wen_ext && (addr_ext != 0 || wdata_ext != 0)) dflt_bad = 1'b1;
        if (!wen_ext_2 && !ren_ext_2 && addr_ext_2 != 0) dflt_bad = 1'b1;
        if (!wen_ext_2 && wdata_ext_2 != 0) dflt_bad = 1'b1;
        if (prev_stall && (!out_valid || out_data != prev_out)) hold_bad = 1'b1;
        prev_stall = out_valid && !out_ready;
        prev_out   = out_data;
        if (out_valid && out_ready) got_dump.push_back(out_data);
    end

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_prog(input int ni, input int nd, input int nn, input int rc,
                            input bit stall, input bit chk_lat);
        logic [63:0] q [$];
        logic [63:0] exp_dump [$];
        logic [63:0] w;
        int cyc, done_cyc;
        bit done_seen;
        for (int i = 0; i < ni; i++) begin
            w = {$urandom, $urandom};
            q.push_back(w);
            exp_imem[i] = w[31:0];
        end
        for (int i = 0; i < nd; i++) begin
            w = {$urandom, $urandom};
            q.push_back(w);
            exp_dmem[i] = w;
        end
        for (int i = 0; i < nn; i++) exp_dump.push_back(exp_dmem[i]);
        en_cnt = 0; en_runs = 0; wr_i = 0; wr_d = 0;
        got_dump.delete();
        ren_bad = 0; dflt_bad = 0; hold_bad = 0;
        start = 1'b1;
        n_inst = 16'(ni); n_data = 16'(nd); n_dump = 16'(nn); run_cycles = 32'(rc);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_inst = 16'($urandom); n_data = 16'($urandom); n_dump = 16'($urandom);
        run_cycles = $urandom;
        cyc = 1; done_seen = 0; done_cyc = 0;
        while (!done_seen && cyc < 3000) begin
            in_valid  = (q.size() > 0) && (!stall || $urandom_range(0, 1) == 1);
            in_data   = (q.size() > 0) ? q[0] : 64'h0;
            out_ready = !stall || ($urandom_range(0, 2) == 0);
            start     = stall && busy && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (in_valid && in_ready) void'(q.pop_front());
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_eq("done_reached", 64'(done_seen), 64'd1);
        if (chk_lat) check_eq("done_cycle", 64'(done_cyc), 64'(ni + nd + rc + 3 * nn + 1));
        check_eq("busy_in_done", 64'(busy), 64'd0);
        check_eq("run_cycles", 64'(en_cnt), 64'(rc));
        check_eq("run_windows", 64'(en_runs), 64'(rc != 0));
        check_eq("inst_writes", 64'(wr_i), 64'(ni));
        check_eq("data_writes", 64'(wr_d), 64'(nd));
        for (int i = 0; i < ni; i++) check_eq($sformatf("imem[%0d]", i), 64'(imem[i]), 64'(exp_imem[i]));
        for (int i = 0; i < nd; i++) check_eq($sformatf("dmem[%0d]", i), dmem[i], exp_dmem[i]);
        check_eq("dump_count", 64'(got_dump.size()), 64'(nn));
        for (int i = 0; i < nn && i < got_dump.size(); i++)
            check_eq($sformatf("dump[%0d]", i), got_dump[i], exp_dump[i]);
        check_eq("ren_ext_zero", 64'(ren_bad), 64'd0);
        check_eq("strobe_defaults", 64'(dflt_bad), 64'd0);
        check_eq("out_hold", 64'(hold_bad), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = '0; dmem[i] = '0; exp_imem[i] = '0; exp_dmem[i] = '0;
        end
        arst_n = 1'b1;
        #1 arst_n = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_cpu_enable", 64'(cpu_enable), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_wen_ext", 64'(wen_ext), 64'd0);
        check_eq("rst_ren_ext_2", 64'(ren_ext_2), 64'd0);
        check_eq("rst_addr_ext_2", addr_ext_2, 64'd0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        run_prog(3, 2, 0, 0, 0, 1);
        run_prog(0, 0, 0, 0, 0, 1);
        run_prog(0, 0, 0, 5, 0, 1);
        run_prog(0, 2, 2, 0, 0, 1);
        run_prog(2, 4, 3, 2, 1, 0);

        // Reset in the middle of a run window.
        start = 1'b1; n_inst = '0; n_data = '0; n_dump = '0; run_cycles = 32'd50;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("en_before_rst", 64'(cpu_enable), 64'd1);
        arst_n = 1'b0;
        #1;
        check_eq("rst_mid_cpu_enable", 64'(cpu_enable), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_done", 64'(done), 64'd0);
        @(posedge clk); #1 arst_n = 1'b1;
        run_prog(2, 1, 1, 3, 0, 1);

        for (int t = 0; t < 8; t++)
            run_prog($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 24),
                     $urandom_range(0, 30), 1'($urandom_range(0, 1)), 1'b0);
        run_prog($urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(1, 10),
                 $urandom_range(1, 10), 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
